// File: rtl/counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_pkg : parameter legality check and Gray conversion for counter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam int c_MAX_WIDTH = 31;

  function automatic bit params_ok(
    input int width,
    input int max_val,
    input int step,
    input int down,
    input int reset_val,
    input int wrapw
  );
    bit ok;
    ok = (width >= 1) && (width <= c_MAX_WIDTH);
    if (ok) begin
      ok = (max_val >= 1) && (max_val <= ((1 << width) - 1)) &&
           (step >= 1) && (step <= max_val) &&
           (down == 0 || down == 1) &&
           (reset_val >= 0) && (reset_val <= max_val) &&
           (wrapw >= 1) && (wrapw <= 32);
    end
    return ok;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_next.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_next : combinational next-count and wrap detection
// Revision     : 1.0
// ---------------------------------------------------------------------------
module counter_next #(
  parameter int WIDTH   = 3,
  parameter int MAX_VAL = 7,
  parameter int STEP    = 1,
  parameter int DOWN    = 0
) (
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] nxt,
  output logic             wrapped
);

  localparam logic [WIDTH:0] c_STEP = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] c_MAX  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] c_MOD  = (WIDTH+1)'(MAX_VAL + 1);

  if (DOWN == 0) begin : g_up
    logic [WIDTH:0] sum;
    always_comb begin
      sum     = {1'b0, count} + c_STEP;
      nxt     = WIDTH'(sum);
      wrapped = 1'b0;
      if (sum > c_MAX) begin
        nxt     = WIDTH'(sum - c_MOD);
        wrapped = 1'b1;
      end
    end
  end else begin : g_down
    logic [WIDTH:0] ext;
    always_comb begin
      ext     = {1'b0, count};
      nxt     = WIDTH'(ext - c_STEP);
      wrapped = 1'b0;
      // Borrow: fold back into range by adding the modulus first.
      if (ext < c_STEP) begin
        nxt     = WIDTH'(ext + c_MOD - c_STEP);
        wrapped = 1'b1;
      end
    end
  end

endmodule : counter_next
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter  : free-running modulo counter with tc, Gray copy and wrap tally
// Revision : 1.0
// ---------------------------------------------------------------------------
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MAX_VAL   = (1 << WIDTH) - 1,
  parameter int STEP      = 1,
  parameter int DOWN      = 0,
  parameter int RESET_VAL = 0,
  parameter int WRAPW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             wrap,
  output logic [WRAPW-1:0] wrap_cnt
);

  if (!params_ok(WIDTH, MAX_VAL, STEP, DOWN, RESET_VAL, WRAPW)) begin : g_bad_params
    $error("counter: illegal parameter set");
  end

  localparam logic [WIDTH-1:0] c_RESET  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_TC_VAL = (DOWN != 0) ? '0 : WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [WIDTH-1:0] nxt;
  logic             wrapped;

  counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP    (STEP),
    .DOWN    (DOWN)
  ) u_next (
    .count   (count_q),
    .nxt     (nxt),
    .wrapped (wrapped)
  );

  always_comb begin
    count_d    = nxt;
    wrap_d     = wrapped;
    wrap_cnt_d = wrap_cnt_q;
    if (wrapped && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + 1'b1;
    end
  end

  // rst is active-low despite its name.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= c_RESET;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign count      = count_q;
  assign count_gray = WIDTH'(bin2gray(32'(count_q)));
  assign tc         = (count_q == c_TC_VAL);
  assign wrap       = wrap_q;
  assign wrap_cnt   = wrap_cnt_q;

endmodule : counter
`default_nettype wire

// File: tb/tb_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_counter : directed self-checking bench for counter and its variants
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  logic [2:0] d_count, d_gray;
  logic       d_tc, d_wrap;
  logic [7:0] d_wcnt;

  logic [2:0] m_count, m_gray;
  logic       m_tc, m_wrap;
  logic [7:0] m_wcnt;

  logic [2:0] s_count, s_gray;
  logic       s_tc, s_wrap;
  logic [7:0] s_wcnt;

  logic [2:0] n_count, n_gray;
  logic       n_tc, n_wrap;
  logic [7:0] n_wcnt;

  logic [2:0] t_count, t_gray;
  logic       t_tc, t_wrap;
  logic [1:0] t_wcnt;

  counter u_dut (
    .clk(clk), .rst(rst), .count(d_count), .count_gray(d_gray),
    .tc(d_tc), .wrap(d_wrap), .wrap_cnt(d_wcnt)
  );

  counter #(.MAX_VAL(5)) u_max5 (
    .clk(clk), .rst(rst), .count(m_count), .count_gray(m_gray),
    .tc(m_tc), .wrap(m_wrap), .wrap_cnt(m_wcnt)
  );

  counter #(.STEP(3)) u_step3 (
    .clk(clk), .rst(rst), .count(s_count), .count_gray(s_gray),
    .tc(s_tc), .wrap(s_wrap), .wrap_cnt(s_wcnt)
  );

  counter #(.DOWN(1)) u_down (
    .clk(clk), .rst(rst), .count(n_count), .count_gray(n_gray),
    .tc(n_tc), .wrap(n_wrap), .wrap_cnt(n_wcnt)
  );

  counter #(.WRAPW(2)) u_sat (
    .clk(clk), .rst(rst), .count(t_count), .count_gray(t_gray),
    .tc(t_tc), .wrap(t_wrap), .wrap_cnt(t_wcnt)
  );

  // Pulse reset low for one cycle, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #10;
    tests++; if (d_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", d_count); end
    tests++; if (d_wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %0d expected 0", d_wrap); end
    tests++; if (d_wcnt !== 8'd0) begin fails++; $display("FAIL reset_wrap_cnt: got %0d expected 0", d_wcnt); end
    tests++; if (d_tc !== 1'b0) begin fails++; $display("FAIL reset_tc: got %0d expected 0", d_tc); end
    tests++; if (d_gray !== 3'd0) begin fails++; $display("FAIL reset_gray: got %0d expected 0", d_gray); end
  endtask

  task automatic test_count();
    logic [2:0] exp_c [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    logic [2:0] exp_g [10] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                               3'b101, 3'b100, 3'b000, 3'b001, 3'b011};
    logic       exp_w [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       exp_t [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++; if (d_count !== exp_c[i]) begin fails++; $display("FAIL count[%0d]: got %0d expected %0d", i, d_count, exp_c[i]); end
      tests++; if (d_gray !== exp_g[i]) begin fails++; $display("FAIL gray[%0d]: got %b expected %b", i, d_gray, exp_g[i]); end
      tests++; if (d_wrap !== exp_w[i]) begin fails++; $display("FAIL wrap[%0d]: got %0d expected %0d", i, d_wrap, exp_w[i]); end
      tests++; if (d_tc !== exp_t[i]) begin fails++; $display("FAIL tc[%0d]: got %0d expected %0d", i, d_tc, exp_t[i]); end
    end
    tests++; if (d_wcnt !== 8'd1) begin fails++; $display("FAIL wrap_cnt_after_run: got %0d expected 1", d_wcnt); end
  endtask

  task automatic test_mid_reset();
    // From count=2, six edges reach 0 with a wrap pulse showing.
    repeat (6) @(negedge clk);
    tests++; if (d_wrap !== 1'b1) begin fails++; $display("FAIL pre_reset_wrap: got %0d expected 1", d_wrap); end
    tests++; if (d_wcnt !== 8'd2) begin fails++; $display("FAIL pre_reset_wrap_cnt: got %0d expected 2", d_wcnt); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (d_count !== 3'd0) begin fails++; $display("FAIL async_count: got %0d expected 0", d_count); end
    tests++; if (d_wcnt !== 8'd0) begin fails++; $display("FAIL async_wrap_cnt: got %0d expected 0", d_wcnt); end
    tests++; if (d_wrap !== 1'b0) begin fails++; $display("FAIL async_wrap: got %0d expected 0", d_wrap); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++; if (d_count !== 3'd0 || d_wrap !== 1'b0) begin
        fails++; $display("FAIL held_reset[%0d]: got count %0d wrap %0d expected 0 0", i, d_count, d_wrap);
      end
    end
  endtask

  task automatic test_max5();
    logic [2:0] exp_c [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic       exp_w [7] = '{0, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      tests++; if (m_count !== exp_c[i] || m_wrap !== exp_w[i]) begin
        fails++; $display("FAIL max5[%0d]: got count %0d wrap %0d expected %0d %0d", i, m_count, m_wrap, exp_c[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_step3();
    logic [2:0] exp_c [7] = '{3'd0, 3'd3, 3'd6, 3'd1, 3'd4, 3'd7, 3'd2};
    logic       exp_w [7] = '{0, 0, 0, 1, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      tests++; if (s_count !== exp_c[i] || s_wrap !== exp_w[i]) begin
        fails++; $display("FAIL step3[%0d]: got count %0d wrap %0d expected %0d %0d", i, s_count, s_wrap, exp_c[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_down();
    logic [2:0] exp_c [9] = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic       exp_w [9] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic       exp_t [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      tests++; if (n_count !== exp_c[i] || n_wrap !== exp_w[i] || n_tc !== exp_t[i]) begin
        fails++; $display("FAIL down[%0d]: got count %0d wrap %0d tc %0d expected %0d %0d %0d",
                          i, n_count, n_wrap, n_tc, exp_c[i], exp_w[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_n [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      repeat (8) @(negedge clk);
      tests++; if (t_wcnt !== exp_n[k]) begin
        fails++; $display("FAIL sat_wrap_cnt[%0d]: got %0d expected %0d", k, t_wcnt, exp_n[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_mid_reset();
    test_max5();
    test_step3();
    test_down();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_counter
`default_nettype wire

// File: doc/counter.md
Name: counter

Overview:
- Free-running, parameterizable modulo counter; default is 3-bit, counting 0..7 and wrapping.
- Used as a simple sequence/timebase source. No enable or load inputs; the block always counts when out of reset.
- Also provides a terminal-count flag, a registered wrap pulse, a Gray-coded copy of the count, and a saturating wrap tally. Downstream logic may leave these unconnected.

Parameters:
- WIDTH, 3, count width in bits (>=1).
- MAX_VAL, 2**WIDTH-1, last value of the count range; legal range 1..2**WIDTH-1.
- STEP, 1, increment/decrement per clock; legal range 1..MAX_VAL.
- DOWN, 0, 0 = count up, 1 = count down.
- RESET_VAL, 0, count value in reset; legal range 0..MAX_VAL.
- WRAPW, 8, width of the wrap tally.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset, 1 = run).
- count  out  WIDTH  current count, registered.
- count_gray  out  WIDTH  Gray code of count: count ^ (count>>1), combinational from count.
- tc  out  1  terminal count, combinational. High when count==MAX_VAL (DOWN=0) or count==0 (DOWN=1).
- wrap  out  1  registered one-cycle pulse in the cycle after the count wraps.
- wrap_cnt  out  WRAPW  number of wraps since reset; saturates at all-ones.

Behaviour:
- Reset: rst==0 forces count=RESET_VAL, wrap=0, wrap_cnt=0 immediately (async), independent of clk.
- Outputs while in reset: count_gray and tc follow count.
- Reset release is sampled synchronously. The first count change happens on the first rising clk edge with rst==1.
- Up mode (DOWN=0), each rising edge with rst==1: nxt = count+STEP, computed in WIDTH+1 bits.
  - If nxt > MAX_VAL: count <= nxt-(MAX_VAL+1), wrap <= 1.
  - Otherwise: count <= nxt, wrap <= 0.
- Down mode (DOWN=1): if count < STEP then count <= count+MAX_VAL+1-STEP and wrap <= 1; otherwise count <= count-STEP and wrap <= 0.
- Defaults: up, STEP=1, MAX=7, giving 0,1,...,7,0,... with no gaps.
- Latency: count changes exactly one clock after each edge; no pipeline.
- wrap_cnt increments on the same edge that sets wrap=1, unless already all-ones (then it holds).
- Reset mid-operation: count returns to RESET_VAL asynchronously, mid-cycle if necessary. A wrap pulse in flight is cleared.
- Reset held across many clock edges: count stays at RESET_VAL and no wrap pulse occurs.
- Non power-of-two MAX_VAL: count never leaves 0..MAX_VAL.
- Out-of-range parameters: rejected at elaboration (generate-time check / $error).

Decomposition:
- Shared package counter_pkg holds:
  - the parameter legality check function;
  - bin2gray function.
- One sub-module is natural: counter_next, purely combinational, taking (count, DOWN, STEP, MAX_VAL) and producing (nxt, wrapped).
- The top level holds the registers, tc, Gray conversion and wrap tally.

Test Plan:
- Hold rst=0 for 10 ns with clk toggling (10 ns period) -> count=0, wrap=0, wrap_cnt=0, tc=0, count_gray=0.
- Release rst=1 for 100 ns (10 edges) -> count sequence 1,2,3,4,5,6,7,0,1,2; then:
  - wrap=1 only in the cycle after 7->0;
  - wrap_cnt=1;
  - tc=1 only while count=7.
- Check Gray output during the run -> count 5 gives count_gray=3'b111; count 7 gives 3'b100; one bit changes per step.
- Reassert rst=0 mid-cycle (between edges) -> count=0 and wrap_cnt=0 immediately. Count holds 0 for 100 ns of clocks while rst stays low.
- Variant MAX_VAL=5 -> sequence 0,1,2,3,4,5,0. Variant STEP=3, MAX_VAL=7 -> 0,3,6,1,4,7,2. Each wrap pulses wrap.
- Variant DOWN=1 -> 0,7,6,...,1,0; wrap after 0->7; tc=1 while count=0. Variant WRAPW=2 with 5 wraps -> wrap_cnt saturates at 3.
